// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with registered encoded and one-hot grants.
// A grant is held until the owner drops its request, pulses done, or the hold timer expires.
module rr_arbiter8 #(
   parameter int MAX_HOLD = 16,
   parameter int CNT_W    = 5
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] req_i,
   input  logic       done_i,
   output logic       grant_valid_o,
   output logic [2:0] grant_idx_o,
   output logic [7:0] grant_onehot_o,
   output logic       timeout_o
);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_e;

   localparam bit             TMO_EN    = (MAX_HOLD != 0);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

   state_e           state_q, state_d;
   logic             valid_q, valid_d;
   logic [2:0]       idx_q, idx_d;
   logic [7:0]       onehot_q, onehot_d;
   logic             tmo_q, tmo_d;
   logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
   logic [2:0]       last_idx_q, last_idx_d;

   logic             rel_owner_s;
   logic             rel_done_s;
   logic             rel_timer_s;
   logic             release_s;
   logic [2:0]       winner_s;

   // First requester at or after last+1, wrapping 7->0 through 3-bit overflow.
   function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] last);
      logic [2:0] cand;
      logic [2:0] win;
      logic       found;
      win   = 3'd0;
      found = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         cand = last + 3'(k);
         if (!found && req[cand]) begin
            win   = cand;
            found = 1'b1;
         end
      end
      return win;
   endfunction

   function automatic logic [7:0] decode3to8(input logic [2:0] idx);
      return 8'h01 << idx;
   endfunction

   assign winner_s    = rr_pick(req_i, last_idx_q);
   assign rel_owner_s = ~req_i[idx_q];
   assign rel_done_s  = done_i;
   assign rel_timer_s = TMO_EN && (hold_cnt_q == HOLD_LAST);
   assign release_s   = rel_owner_s | rel_done_s | rel_timer_s;

   // Next-state and registered-output computation.
   always_comb begin
      state_d    = state_q;
      valid_d    = valid_q;
      idx_d      = idx_q;
      onehot_d   = onehot_q;
      tmo_d      = 1'b0;
      hold_cnt_d = hold_cnt_q;
      last_idx_d = last_idx_q;
      case (state_q)
         ST_IDLE: begin
            if (req_i != 8'h00) begin
               state_d    = ST_GRANT;
               valid_d    = 1'b1;
               idx_d      = winner_s;
               onehot_d   = decode3to8(winner_s);
               hold_cnt_d = {CNT_W{1'b0}};
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_GRANT: begin
            if (release_s) begin
               state_d    = ST_IDLE;
               valid_d    = 1'b0;
               onehot_d   = 8'h00;
               last_idx_d = idx_q;
               hold_cnt_d = {CNT_W{1'b0}};
               // The pulse flags only a release the owner did not ask for.
               tmo_d      = rel_timer_s & ~rel_owner_s & ~rel_done_s;
            end else if (hold_cnt_q != CNT_MAX) begin
               hold_cnt_d = hold_cnt_q + CNT_W'(1);
            end else begin
               hold_cnt_d = hold_cnt_q;
            end
         end
         default: begin
            state_d  = ST_IDLE;
            valid_d  = 1'b0;
            onehot_d = 8'h00;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         valid_q    <= 1'b0;
         idx_q      <= 3'd0;
         onehot_q   <= 8'h00;
         tmo_q      <= 1'b0;
         hold_cnt_q <= {CNT_W{1'b0}};
         last_idx_q <= 3'd7;
      end else begin
         state_q    <= state_d;
         valid_q    <= valid_d;
         idx_q      <= idx_d;
         onehot_q   <= onehot_d;
         tmo_q      <= tmo_d;
         hold_cnt_q <= hold_cnt_d;
         last_idx_q <= last_idx_d;
      end
   end

   assign grant_valid_o  = valid_q;
   assign grant_idx_o    = idx_q;
   assign grant_onehot_o = onehot_q;
   assign timeout_o      = tmo_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed and randomized checks of the eight-way round-robin arbiter
// against hand-computed values and a small behavioural reference model.
module tb_rr_arbiter8;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] req;
   logic       done;
   logic       valid;
   logic [2:0] idx;
   logic [7:0] oh;
   logic       tmo;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   rr_arbiter8 #(.MAX_HOLD(16), .CNT_W(5)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .req_i          (req),
      .done_i         (done),
      .grant_valid_o  (valid),
      .grant_idx_o    (idx),
      .grant_onehot_o (oh),
      .timeout_o      (tmo)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req   = 8'h00;
      done  = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req   = 8'hFF;
      done  = 1'b0;
      #3;
      checks++;
      if (valid !== 1'b0 || oh !== 8'h00) begin
         errors++;
         $display("FAIL reset_out: valid=%b onehot=%h expected 0/00", valid, oh);
      end
      checks++;
      if (idx !== 3'd0 || tmo !== 1'b0) begin
         errors++;
         $display("FAIL reset_idx: idx=%0d timeout=%b expected 0/0", idx, tmo);
      end
      step();
      checks++;
      if (valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_hold: valid=%b expected 0 while rst_n low", valid);
      end
      rst_n = 1'b1;
      req   = 8'h00;
      step();
   endtask

   task automatic test_rotation();
      logic [7:0] exp_oh;
      req = 8'hFF;
      step();
      for (int n = 0; n <= 8; n++) begin
         exp_oh = 8'h01 << (n % 8);
         checks++;
         if (valid !== 1'b1 || idx !== 3'(n % 8) || oh !== exp_oh) begin
            errors++;
            $display("FAIL rotation_grant%0d: valid=%b idx=%0d onehot=%h expected 1/%0d/%h",
                     n, valid, idx, oh, n % 8, exp_oh);
         end
         done = 1'b1;
         step();
         checks++;
         if (valid !== 1'b0 || oh !== 8'h00) begin
            errors++;
            $display("FAIL rotation_bubble%0d: valid=%b onehot=%h expected 0/00", n, valid, oh);
         end
         done = 1'b0;
         if (n == 8) req = 8'h00;
         step();
      end
   endtask

   task automatic test_wrap();
      do_reset();
      req = 8'h20;
      step();
      checks++;
      if (valid !== 1'b1 || idx !== 3'd5) begin
         errors++;
         $display("FAIL wrap_first: valid=%b idx=%0d expected 1/5", valid, idx);
      end
      req  = 8'b0010_0001;
      done = 1'b1;
      step();
      done = 1'b0;
      step();
      checks++;
      if (valid !== 1'b1 || idx !== 3'd0 || oh !== 8'h01) begin
         errors++;
         $display("FAIL wrap_to0: valid=%b idx=%0d onehot=%h expected 1/0/01", valid, idx, oh);
      end
      done = 1'b1;
      step();
      done = 1'b0;
      step();
      checks++;
      if (valid !== 1'b1 || idx !== 3'd5 || oh !== 8'h20) begin
         errors++;
         $display("FAIL wrap_to5: valid=%b idx=%0d onehot=%h expected 1/5/20", valid, idx, oh);
      end
      done = 1'b1;
      req  = 8'h00;
      step();
      done = 1'b0;
      step();
   endtask

   task automatic test_timeout();
      int cnt;
      req = 8'h08;
      step();
      checks++;
      if (valid !== 1'b1 || idx !== 3'd3) begin
         errors++;
         $display("FAIL timeout_grant: valid=%b idx=%0d expected 1/3", valid, idx);
      end
      cnt = 0;
      while (valid === 1'b1 && cnt < 40) begin
         cnt++;
         checks++;
         if (tmo !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early: timeout=%b at held cycle %0d expected 0", tmo, cnt);
         end
         step();
      end
      checks++;
      if (cnt != 16) begin
         errors++;
         $display("FAIL timeout_len: held %0d cycles expected 16", cnt);
      end
      checks++;
      if (tmo !== 1'b1) begin
         errors++;
         $display("FAIL timeout_pulse: timeout=%b expected 1", tmo);
      end
      step();
      checks++;
      if (valid !== 1'b1 || idx !== 3'd3 || tmo !== 1'b0) begin
         errors++;
         $display("FAIL timeout_regrant: valid=%b idx=%0d timeout=%b expected 1/3/0", valid, idx, tmo);
      end
   endtask

   task automatic test_coincide();
      repeat (15) step();
      checks++;
      if (valid !== 1'b1) begin
         errors++;
         $display("FAIL coincide_held: valid=%b expected 1 before expiry", valid);
      end
      req  = 8'h00;
      done = 1'b1;
      step();
      checks++;
      if (valid !== 1'b0 || tmo !== 1'b0) begin
         errors++;
         $display("FAIL coincide_release: valid=%b timeout=%b expected 0/0", valid, tmo);
      end
      req  = 8'h08;
      done = 1'b0;
      step();
      checks++;
      if (valid !== 1'b1 || idx !== 3'd3 || tmo !== 1'b0) begin
         errors++;
         $display("FAIL coincide_regrant: valid=%b idx=%0d timeout=%b expected 1/3/0", valid, idx, tmo);
      end
      done = 1'b1;
      req  = 8'h00;
      step();
      done = 1'b0;
      step();
   endtask

   task automatic test_reset_mid();
      req = 8'h40;
      step();
      checks++;
      if (valid !== 1'b1 || idx !== 3'd6 || oh !== 8'h40) begin
         errors++;
         $display("FAIL midrst_grant: valid=%b idx=%0d onehot=%h expected 1/6/40", valid, idx, oh);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (valid !== 1'b0 || oh !== 8'h00 || idx !== 3'd0) begin
         errors++;
         $display("FAIL midrst_async: valid=%b onehot=%h idx=%0d expected 0/00/0", valid, oh, idx);
      end
      req = 8'h41;
      #2;
      rst_n = 1'b1;
      step();
      checks++;
      if (valid !== 1'b1 || idx !== 3'd0 || oh !== 8'h01) begin
         errors++;
         $display("FAIL midrst_regrant: valid=%b idx=%0d onehot=%h expected 1/0/01", valid, idx, oh);
      end
      done = 1'b1;
      req  = 8'h00;
      step();
      done = 1'b0;
   endtask

   task automatic test_random();
      bit         mv;
      int         mi;
      int         ml;
      int         mc;
      bit         mt;
      bit         rel;
      bit         prev_valid;
      logic [7:0] prev_req;
      logic [7:0] exp_oh;
      int         wait_n[8];
      int         worst;
      int         j;
      do_reset();
      mv = 1'b0; mi = 0; ml = 7; mc = 0; mt = 1'b0;
      prev_valid = 1'b0;
      prev_req   = 8'h00;
      for (int i = 0; i < 8; i++) wait_n[i] = 0;
      for (int cyc = 0; cyc < 2000; cyc++) begin
         for (int b = 0; b < 8; b++) begin
            if ($urandom_range(0, 15) == 0) req[b] = ~req[b];
         end
         done = ($urandom_range(0, 3) == 0);
         for (int b = 0; b < 8; b++) begin
            if (!req[b] || !prev_req[b]) wait_n[b] = 0;
         end
         if (mv) begin
            rel = (req[mi] == 1'b0) || done || (mc == 15);
            if (rel) begin
               mt = (mc == 15) && req[mi] && !done;
               mv = 1'b0;
               ml = mi;
               mc = 0;
            end else begin
               mt = 1'b0;
               if (mc < 31) mc++;
            end
         end else begin
            mt = 1'b0;
            if (req != 8'h00) begin
               j = -1;
               for (int k = 1; k <= 8; k++) begin
                  if (j < 0 && req[(ml + k) % 8]) j = (ml + k) % 8;
               end
               mi = j;
               mv = 1'b1;
               mc = 0;
            end
         end
         step();
         exp_oh = mv ? (8'h01 << mi) : 8'h00;
         checks++;
         if (valid !== mv || idx !== 3'(mi) || oh !== exp_oh || tmo !== mt) begin
            errors++;
            $display("FAIL random_model cyc%0d: valid=%b idx=%0d onehot=%h timeout=%b expected %b/%0d/%h/%b",
                     cyc, valid, idx, oh, tmo, mv, mi, exp_oh, mt);
         end
         checks++;
         if (!((oh === 8'h00 && valid === 1'b0) || ($onehot(oh) && valid === 1'b1))) begin
            errors++;
            $display("FAIL random_onehot cyc%0d: valid=%b onehot=%h expected consistent one-hot", cyc, valid, oh);
         end
         if (valid === 1'b1 && !prev_valid) begin
            worst = 0;
            for (int b = 0; b < 8; b++) begin
               if (req[b]) begin
                  if (3'(b) == idx) wait_n[b] = 0;
                  else wait_n[b]++;
                  if (wait_n[b] > worst) worst = wait_n[b];
               end
            end
            checks++;
            if (worst > 7) begin
               errors++;
               $display("FAIL random_starve cyc%0d: waited %0d grants expected at most 7", cyc, worst);
            end
         end
         prev_valid = (valid === 1'b1);
         prev_req   = req;
      end
      req  = 8'h00;
      done = 1'b0;
      step();
      step();
   endtask

   initial begin
      rst_n = 1'b0;
      req   = 8'h00;
      done  = 1'b0;
      test_reset();
      test_rotation();
      test_wrap();
      test_timeout();
      test_coincide();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
